// File: rtl/mux_pkg.sv
// Shared sizes and types for the round-robin 4:1 mux feeder.
package mux_pkg;
   localparam int DATA_W = 16;
   localparam int N_CH   = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;
endpackage

// File: rtl/rr_mux_feeder_pick.sv
// Round-robin picker: first set request scanning start, start+1, ... mod 4.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick
   import mux_pkg::*;
(
   input  logic [3:0] req_i,
   input  sel_t       start_i,
   output sel_t       grant_o,
   output logic       any_o
);

   sel_t idx;

   // Walk the scan order backwards so the closest request to start_i wins last.
   always_comb begin
      grant_o = start_i;
      any_o   = 1'b0;
      idx     = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = start_i + sel_t'(k);
         if (req_i[idx]) begin
            grant_o = idx;
            any_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_feeder.sv
// Four one-word channel buffers presented round-robin to a downstream 4:1 mux via registered S.
// Latency 2 cycles accept-to-out_valid; a full channel deasserts in_ready until its word is taken.
module rr_mux_feeder #(
   parameter int DATA_W = 16,
   parameter int N_CH   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        in_valid,
   output logic [3:0]        in_ready,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic [DATA_W-1:0] in_data3,
   output logic [DATA_W-1:0] I0,
   output logic [DATA_W-1:0] I1,
   output logic [DATA_W-1:0] I2,
   output logic [DATA_W-1:0] I3,
   output logic [1:0]        S,
   output logic              out_valid,
   input  logic              out_ready
);
   import mux_pkg::*;

   state_t            state_q;
   sel_t              ptr_q;
   sel_t              s_q;
   logic [3:0]        full_q;
   logic [3:0]        full_d;
   logic [DATA_W-1:0] data_q  [4];
   logic [DATA_W-1:0] in_data [4];

   logic [3:0] load;
   logic [3:0] others;
   logic       handshake;
   sel_t       idle_grant;
   logic       idle_any;
   sel_t       next_grant;
   logic       next_any;
   sel_t       next_start;

   assign in_data[0] = in_data0;
   assign in_data[1] = in_data1;
   assign in_data[2] = in_data2;
   assign in_data[3] = in_data3;

   assign load       = in_valid & ~full_q;
   assign handshake  = (state_q == PRESENT) && out_ready;
   assign next_start = s_q + 2'd1;

   // Channel being retired is excluded so the follow-on pick never re-grants it.
   always_comb begin
      others      = full_q;
      others[s_q] = 1'b0;
   end

   rr_pick u_pick_idle (
      .req_i   (full_q),
      .start_i (ptr_q),
      .grant_o (idle_grant),
      .any_o   (idle_any)
   );

   rr_pick u_pick_next (
      .req_i   (others),
      .start_i (next_start),
      .grant_o (next_grant),
      .any_o   (next_any)
   );

   // The presented channel is full, so it can never load on its own handshake cycle.
   always_comb begin
      full_d = full_q | load;
      if (handshake) begin
         full_d[s_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         s_q     <= '0;
         full_q  <= '0;
      end else begin
         full_q <= full_d;
         case (state_q)
            IDLE: begin
               if (idle_any) begin
                  s_q     <= idle_grant;
                  state_q <= PRESENT;
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  ptr_q <= next_start;
                  if (next_any) begin
                     s_q <= next_grant;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load[i]) begin
               data_q[i] <= in_data[i];
            end
         end
      end
   end

   assign in_ready  = ~full_q;
   assign out_valid = (state_q == PRESENT);
   assign S         = s_q;
   assign I0        = data_q[0];
   assign I1        = data_q[1];
   assign I2        = data_q[2];
   assign I3        = data_q[3];

endmodule

// File: doc/rr_mux_feeder.md
RR_MUX_FEEDER -- requirements
Module: rr_mux_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the channel data width.
REQ-002 SHALL have parameter N_CH, fixed at 4, giving the number of input channels; the 2-bit select width follows from it.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 4, per-channel producer valid.
REQ-006 SHALL have port in_ready, output, 4, per-channel ready; equals ~full[i].
REQ-007 SHALL have ports in_data0..in_data3, input, DATA_W each, per-channel producer data.
REQ-008 SHALL have ports I0..I3, output, DATA_W each, holding-register contents, which drive the downstream 4:1 mux data inputs.
REQ-009 SHALL have port S, output, 2, registered select, which drives the downstream mux select.
REQ-010 SHALL have port out_valid, output, 1; when high, mux output Y for select S is a valid word.
REQ-011 SHALL have port out_ready, input, 1, downstream consumer ready.

Function
REQ-012 SHALL hold one DATA_W holding register and one full flag per channel.
REQ-013 SHALL load channel i on the cycle with in_valid[i] & in_ready[i]: register i <= in_data_i and full[i] <= 1.
REQ-014 SHALL keep a 2-bit round-robin pointer ptr giving the highest-priority channel.
REQ-015 SHALL use states IDLE and PRESENT; out_valid = (state == PRESENT).
REQ-016 In IDLE with any full[i] set, SHALL pick the first full channel scanning ptr, ptr+1, ... mod 4, register it into S, and go to PRESENT.
REQ-017 In IDLE with no full flag set, SHALL remain in IDLE with S unchanged.
REQ-018 In PRESENT with out_ready low, SHALL hold S, I[S] and out_valid stable.
REQ-019 In PRESENT with out_ready high (handshake), SHALL clear full[S] and set ptr <= S+1 mod 4 (3 wraps to 0).
REQ-020 On the handshake cycle, if any full[j] is set with j != S, SHALL pick the next channel starting from S+1 and stay in PRESENT (back-to-back, no bubble); otherwise SHALL go to IDLE.
REQ-021 The pick SHALL use the full flags before the current cycle's loads; a channel loaded on the same cycle is eligible from the next cycle.
REQ-022 Latency from input accept on cycle N to out_valid on an idle block SHALL be 2 cycles (full at N+1, S/out_valid at N+2).
REQ-023 A channel SHALL never be reloaded while full, since in_ready[i] is low; a channel freed by handshake SHALL show in_ready high on the next cycle.
REQ-024 Holding registers SHALL change only on load; I0..I3 SHALL be driven directly from them.

Reset
REQ-025 On rst_n low, SHALL immediately and asynchronously set: state = IDLE, full = 0 (in_ready = 4'b1111), ptr = 0, S = 0, out_valid = 0, I0..I3 = 0.
REQ-026 Reset asserted mid-handshake SHALL discard all held words, with no output produced after release.
REQ-027 The first load SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package mux_pkg SHALL hold DATA_W, N_CH, the select typedef (logic [1:0]) and the state enum {IDLE, PRESENT}.
REQ-029 SHALL instantiate one combinational sub-module rr_pick (inputs: 4-bit request, 2-bit start; outputs: 2-bit grant index and an any flag) for both pick points.

Verification
REQ-030 Single word: in_valid=4'b0100, in_data2=16'hBEEF, out_ready=1 -> two cycles later out_valid=1, S=2, I2=16'hBEEF; one cycle later out_valid=0 and ptr=3.
REQ-031 All four channels loaded in one cycle with out_ready=1 -> S sequence 0,1,2,3 on consecutive cycles, out_valid high for 4 cycles, then IDLE.
REQ-032 Backpressure: out_ready=0 for 5 cycles with channel 1 full -> S=1 and I1 stable, in_ready[1]=0 throughout; handshake on cycle 6 -> in_ready[1]=1 on cycle 7.
REQ-033 Wrap and fairness: ptr=3 with channels 0 and 3 full -> S=3 first, then S=0.
REQ-034 Reset mid-PRESENT with channels 0-2 full -> out_valid=0, in_ready=4'b1111 and S=0 asynchronously; no output after release until new loads.
REQ-035 Same-cycle load on channel 2 during a channel-1 handshake with no other full channel -> go to IDLE, then S=2 one cycle later.
